fxp_divider: RTL

Parametrised sequential restoring divider producing a fixed-point quotient with F fractional bits from W-bit integer operands, with an integrated controller and a start/done handshake. It is the next generation of the 10-bit unsigned divider datapath: generic width and fraction count, a run-time signed mode, remainder output, divide-by-zero detection, and saturating overflow. It sits as a standalone arithmetic unit driven by a host FSM.

---
 rtl/fxp_div_pkg.sv | 35 +++
 rtl/fxp_divider_if.sv | 25 ++
 rtl/fxp_div_step.sv | 25 ++
 rtl/fxp_divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the fixed-point restoring divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Helper arithmetic is done at a fixed wide width and cast down at call sites.
  localparam int unsigned HW = 64;

  // Magnitude of a w-bit operand; in signed mode -2^(w-1) maps to 2^(w-1).
  function automatic logic [HW-1:0] mag_fn(input logic [HW-1:0] x,
                                           input int unsigned   w,
                                           input logic          sgn);
    logic [HW-1:0] mask;
    logic          msb;
    mask = (HW'(1) << w) - HW'(1);
    msb  = x[6'(w - 1)];
    if (sgn && msb) return (~x + HW'(1)) & mask;
    return x & mask;
  endfunction

  // Largest quotient magnitude representable in a w-bit result.
  function automatic logic [HW-1:0] limit_fn(input int unsigned w,
                                             input logic        sgn,
                                             input logic        neg);
    if (!sgn) return (HW'(1) << w) - HW'(1);
    if (neg)  return HW'(1) << (w - 1);
    return (HW'(1) << (w - 1)) - HW'(1);
  endfunction

endpackage

// File: rtl/fxp_divider_if.sv
// Start/done handshake and operand/result bus between host and divider.
interface fxp_divider_if #(
  parameter int unsigned W = 10
);
  logic         start;
  logic         is_signed;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         ovf;
  logic         dz;

  modport master (
    output start, is_signed, a_in, b_in,
    input  busy, done, q_out, r_out, ovf, dz
  );

  modport slave (
    input  start, is_signed, a_in, b_in,
    output busy, done, q_out, r_out, ovf, dz
  );
endinterface

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step on a W+1 bit accumulator.
module fxp_div_step #(
  parameter int unsigned W = 10
) (
  input  logic [W:0] i_acc,
  input  logic       i_bit,
  input  logic [W:0] i_bm,
  output logic [W:0] o_acc_c,
  output logic       o_qbit_c
);

  localparam int unsigned SW = W + 2;

  logic [SW-1:0] w_sh;
  logic [SW-1:0] w_bm;

  // Shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    w_sh     = {i_acc, i_bit};
    w_bm     = SW'(i_bm);
    o_qbit_c = (w_sh >= w_bm);
    o_acc_c  = o_qbit_c ? (W+1)'(w_sh - w_bm) : (W+1)'(w_sh);
  end

endmodule

// File: rtl/fxp_divider.sv
// Sequential restoring divider: W-bit operands, quotient with F fraction bits.
module fxp_divider
  import fxp_div_pkg::*;
#(
  parameter int unsigned W = 10,
  parameter int unsigned F = 4
) (
  input  logic         clk,
  input  logic         sclr_n,
  fxp_divider_if.slave bus
);

  localparam int unsigned QW = W + F;
  localparam int unsigned AW = W + 1;
  localparam int unsigned CW = $clog2(W + F);
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sgn;
  logic [AW-1:0]   r_bm;
  logic [AW-1:0]   r_acc;
  logic [QW-1:0]   r_dvd;
  logic [QW-2:0]   r_q;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_q_out;
  logic [W-1:0]    r_r_out;
  logic            r_ovf;
  logic            r_dz;

  logic [W-1:0]    w_am;
  logic [AW-1:0]   w_bm;
  logic            w_a_neg;
  logic            w_neg;
  logic [AW-1:0]   w_acc_nxt;
  logic            w_qbit;
  logic [QW-1:0]   w_qm;
  logic            w_ovf;
  logic [W-1:0]    w_q_fin;
  logic [W-1:0]    w_r_fin;
  logic [W-1:0]    w_q_dz;

  fxp_div_step #(.W(W)) u_step (
    .i_acc    (r_acc),
    .i_bit    (r_dvd[QW-1]),
    .i_bm     (r_bm),
    .o_acc_c  (w_acc_nxt),
    .o_qbit_c (w_qbit)
  );

  // Operand magnitudes, result sign and saturated final result values.
  always_comb begin
    w_am    = W'(mag_fn(HW'(r_a), W, r_sgn));
    w_bm    = AW'(mag_fn(HW'(r_b), W, r_sgn));
    w_a_neg = r_sgn & r_a[W-1];
    w_neg   = w_a_neg ^ (r_sgn & r_b[W-1]);
    w_qm    = {r_q, w_qbit};
    w_ovf   = (HW'(w_qm) > limit_fn(W, r_sgn, w_neg));
    w_q_fin = w_qm[W-1:0];
    if (w_ovf) begin
      w_q_fin = r_sgn ? (w_neg ? SMIN : SMAX) : '1;
    end else if (w_neg) begin
      w_q_fin = W'(0) - w_qm[W-1:0];
    end
    w_r_fin = w_a_neg ? (W'(0) - w_acc_nxt[W-1:0]) : w_acc_nxt[W-1:0];
    w_q_dz  = r_sgn ? (w_a_neg ? SMIN : SMAX) : '1;
  end

  // Controller, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_bm    <= '0;
      r_acc   <= '0;
      r_dvd   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= LOAD;
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_sgn   <= bus.is_signed;
            r_busy  <= 1'b1;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
          end
        end
        LOAD: begin
          r_bm  <= w_bm;
          r_acc <= '0;
          r_q   <= '0;
          r_dvd <= QW'(w_am) << F;
          r_cnt <= CW'(QW - 1);
          if (w_bm == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_dz    <= 1'b1;
            r_ovf   <= 1'b0;
            r_q_out <= w_q_dz;
            r_r_out <= r_a;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_qm[QW-2:0];
          r_dvd <= r_dvd << 1;
          if (r_cnt == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_q_out <= w_q_fin;
            r_r_out <= w_r_fin;
            r_ovf   <= w_ovf;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.q_out = r_q_out;
  assign bus.r_out = r_r_out;
  assign bus.ovf   = r_ovf;
  assign bus.dz    = r_dz;

endmodule
